mouse_receiver: RTL and testbench

PS/2 receive stage feeding the mouse master state machine. Deserialises 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop) from the open-collector mouse clock/data lines, checks framing and parity, and presents each byte with an error code and a one-cycle ready strobe. Reception is gated by the master's read-enable. Sits between the PS/2 pads and the master state machine.

---
 rtl/mouse_receiver.sv | 142 ++++++++++++++
 tb/tb_mouse_receiver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receive stage: synchronises the pad lines, deserialises
// start/8 data/odd parity/stop frames and strobes each byte with an error code.
module mouse_receiver #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_MOUSE_IN,
   input  logic       DATA_MOUSE_IN,
   input  logic       READ_ENABLE,
   output logic [7:0] BYTE_READ,
   output logic [1:0] BYTE_ERROR_CODE,
   output logic       BYTE_READY,
   output logic [2:0] RECV_STATE
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      PARITY = 3'd2,
      STOP   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             clk_sync_p0;
   logic             clk_sync_p1;
   logic             clk_prev_p2;
   logic             data_sync_p0;
   logic             data_sync_p1;
   logic             fall;
   logic             timed_out;
   logic [2:0]       bit_cnt;
   logic [CNT_W-1:0] timeout_cnt;
   logic [7:0]       shift_reg;
   logic             parity_err;

   // Odd parity over data plus parity bit: the parity bit must equal XNOR of the data.
   function automatic logic parity_error(input logic [7:0] data, input logic pbit);
      return pbit != ~^data;
   endfunction

   // Stage p0/p1: two-flop synchronisers, idle-high after reset; p2: previous clock level
   always_ff @(posedge CLK) begin
      if (RESET) begin
         clk_sync_p0  <= 1'b1;
         clk_sync_p1  <= 1'b1;
         clk_prev_p2  <= 1'b1;
         data_sync_p0 <= 1'b1;
         data_sync_p1 <= 1'b1;
      end else begin
         clk_sync_p0  <= CLK_MOUSE_IN;
         clk_sync_p1  <= clk_sync_p0;
         clk_prev_p2  <= clk_sync_p1;
         data_sync_p0 <= DATA_MOUSE_IN;
         data_sync_p1 <= data_sync_p0;
      end
   end

   assign fall      = clk_prev_p2 & ~clk_sync_p1;
   assign timed_out = (timeout_cnt == TIMEOUT_VAL);

   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   // An edge always takes priority over an expiring timeout.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (fall && READ_ENABLE && !data_sync_p1) state_next = DATA;
         DATA: begin
            if (fall) begin
               if (bit_cnt == 3'd7) state_next = PARITY;
            end else if (timed_out) begin
               state_next = IDLE;
            end
         end
         PARITY: begin
            if (fall)           state_next = STOP;
            else if (timed_out) state_next = IDLE;
         end
         STOP: begin
            if (fall)           state_next = DONE;
            else if (timed_out) state_next = IDLE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         bit_cnt         <= 3'd0;
         timeout_cnt     <= '0;
         BYTE_READ       <= 8'h00;
         BYTE_ERROR_CODE <= 2'b00;
         BYTE_READY      <= 1'b0;
      end else begin
         BYTE_READY <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt     <= 3'd0;
               timeout_cnt <= '0;
            end
            DATA, PARITY: begin
               if (fall) begin
                  timeout_cnt <= '0;
                  if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
               end else begin
                  timeout_cnt <= timeout_cnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (fall) begin
                  timeout_cnt     <= '0;
                  BYTE_READ       <= shift_reg;
                  BYTE_ERROR_CODE <= {~data_sync_p1, parity_err};
                  BYTE_READY      <= 1'b1;
               end else begin
                  timeout_cnt <= timeout_cnt + CNT_W'(1);
               end
            end
            default: timeout_cnt <= '0;
         endcase
      end
   end

   // Payload registers are fully rewritten by every frame, so they carry no reset.
   always_ff @(posedge CLK) begin
      if (fall && state == DATA)   shift_reg[bit_cnt] <= data_sync_p1;
      if (fall && state == PARITY) parity_err <= parity_error(shift_reg, data_sync_p1);
   end

   assign RECV_STATE = state;

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed bench for mouse_receiver: frame-level model of the PS/2 receiver
// checked every cycle, plus literal expectations per test step.
module tb_mouse_receiver;

   localparam int TMO = 100;
   localparam int H   = 10;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       mclk  = 1'b1;
   logic       mdata = 1'b1;
   logic       re    = 1'b1;
   logic [7:0] byte_read;
   logic [1:0] code;
   logic       ready;
   logic [2:0] rstate;

   mouse_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLK            (clk),
      .RESET          (rst),
      .CLK_MOUSE_IN   (mclk),
      .DATA_MOUSE_IN  (mdata),
      .READ_ENABLE    (re),
      .BYTE_READ      (byte_read),
      .BYTE_ERROR_CODE(code),
      .BYTE_READY     (ready),
      .RECV_STATE     (rstate)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int pulse_cyc = 0;
   int stop_fall_cyc = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame-level model: pad levels seen through the synchroniser, bits collected
   // after the start bit, byte reported the cycle after the stop bit is seen.
   logic       m_c0 = 1'b1, m_c1 = 1'b1, m_c2 = 1'b1, m_d0 = 1'b1, m_d1 = 1'b1;
   bit         m_busy = 1'b0;
   int         m_idle = 0;
   int         m_bits[$];
   bit         m_fall;
   logic       m_dbit;
   logic [7:0] m_byte;
   int         m_ones;
   logic [7:0] exp_byte = 8'h00;
   logic [1:0] exp_code = 2'b00;
   logic       exp_ready = 1'b0;

   always @(posedge clk) begin
      m_fall    = m_c2 && !m_c1;
      m_dbit    = m_d1;
      exp_ready = 1'b0;
      if (rst) begin
         m_busy = 1'b0;
         m_bits.delete();
         m_idle = 0;
         exp_byte = 8'h00;
         exp_code = 2'b00;
         {m_c0, m_c1, m_c2, m_d0, m_d1} = 5'b11111;
      end else begin
         if (m_busy) begin
            if (m_fall) begin
               m_bits.push_back(int'(m_dbit));
               m_idle = 0;
               if (m_bits.size() == 10) begin
                  m_ones = 0;
                  for (int k = 0; k < 8; k++) begin
                     m_byte[k] = m_bits[k][0];
                     m_ones += m_bits[k];
                  end
                  exp_byte  = m_byte;
                  exp_code  = {m_bits[9] != 1, ((m_ones + m_bits[8]) % 2) == 0};
                  exp_ready = 1'b1;
                  m_busy    = 1'b0;
                  m_bits.delete();
               end
            end else if (m_idle == TMO) begin
               m_busy = 1'b0;
               m_bits.delete();
            end else begin
               m_idle++;
            end
         end else if (m_fall && m_dbit == 1'b0 && re) begin
            m_busy = 1'b1;
            m_idle = 0;
         end
         m_c2 = m_c1; m_c1 = m_c0; m_c0 = mclk;
         m_d1 = m_d0; m_d0 = mdata;
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("byte_ready", ready, exp_ready);
         chk("byte_read", byte_read, exp_byte);
         chk("error_code", code, exp_code);
         if (ready === 1'b1) begin
            pulse_cnt++;
            pulse_cyc = cyc;
         end
      end
   end

   task automatic send_bits(input logic [10:0] frame, input int nbits, input bit drop_re);
      for (int i = 0; i < nbits; i++) begin
         mdata = frame[i];
         repeat (H) @(negedge clk);
         mclk = 1'b0;
         stop_fall_cyc = cyc;
         repeat (H) @(negedge clk);
         if (i == 0 && drop_re) re = 1'b0;
         mclk = 1'b1;
      end
      mdata = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic p, input logic s, input bit drop_re);
      send_bits({s, p, b, 1'b0}, 11, drop_re);
      repeat (2 * H) @(negedge clk);
      re = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_state", rstate, 0);
      chk("reset_byte", byte_read, 8'h00);
      chk("reset_code", code, 0);
      chk("reset_ready", ready, 0);
      repeat (5) @(negedge clk);

      send_frame(8'hFA, 1'b1, 1'b1, 1'b0);
      chk("fa_pulses", pulse_cnt, 1);
      chk("fa_byte", byte_read, 8'hFA);
      chk("fa_code", code, 2'b00);
      chk("fa_latency", pulse_cyc - stop_fall_cyc, 3);

      send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
      chk("aa_pulses", pulse_cnt, 2);
      chk("aa_byte", byte_read, 8'hAA);
      chk("aa_code", code, 2'b01);

      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      chk("stop_err_byte", byte_read, 8'h00);
      chk("stop_err_code", code, 2'b10);
      send_frame(8'h00, 1'b0, 1'b0, 1'b0);
      chk("both_err_code", code, 2'b11);
      chk("both_err_pulses", pulse_cnt, 4);

      re = 1'b0;
      send_frame(8'h08, 1'b0, 1'b1, 1'b0);
      chk("gated_pulses", pulse_cnt, 4);
      chk("gated_byte", byte_read, 8'h00);
      chk("gated_code", code, 2'b11);

      send_frame(8'h08, 1'b0, 1'b1, 1'b1);
      chk("re_drop_pulses", pulse_cnt, 5);
      chk("re_drop_byte", byte_read, 8'h08);
      chk("re_drop_code", code, 2'b00);

      send_bits({1'b1, 1'b1, 8'h03, 1'b0}, 5, 1'b0);
      chk("partial_state", rstate, 1);
      repeat (TMO + 50) @(negedge clk);
      chk("timeout_state", rstate, 0);
      chk("timeout_pulses", pulse_cnt, 5);
      chk("timeout_byte", byte_read, 8'h08);

      send_frame(8'h03, 1'b1, 1'b1, 1'b0);
      chk("after_to_pulses", pulse_cnt, 6);
      chk("after_to_byte", byte_read, 8'h03);
      chk("after_to_code", code, 2'b00);

      send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 9, 1'b0);
      chk("parity_state", rstate, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_state", rstate, 0);
      chk("midrst_byte", byte_read, 8'h00);
      chk("midrst_code", code, 0);
      chk("midrst_ready", ready, 0);
      repeat (H) @(negedge clk);

      send_frame(8'h08, 1'b0, 1'b1, 1'b0);
      chk("b2b_byte0", byte_read, 8'h08);
      send_frame(8'h01, 1'b0, 1'b1, 1'b0);
      chk("b2b_byte1", byte_read, 8'h01);
      send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
      chk("b2b_byte2", byte_read, 8'hFF);
      chk("b2b_code", code, 2'b00);
      chk("b2b_pulses", pulse_cnt, 9);
      chk("end_state", rstate, 0);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
